// File: rtl/dac_stream_mux.sv
// Multichannel DAC sample streamer: a FIFO feeds CH staging registers on each
// sample tick, and all channels update together in a single LOAD cycle.
module dac_stream_mux #(
  parameter int DW = 10,
  parameter int CH = 2,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_en,
  input  logic [19:0]      clkdiv,
  input  logic             wr,
  input  logic [DW-1:0]    data,
  input  logic [AW:0]      fifo_threshold,
  input  logic             mode,
  input  logic             clr_flags,
  output logic [CH*DW-1:0] dac_data,
  output logic             EN,
  output logic             RST,
  output logic             empty,
  output logic             full,
  output logic             low,
  output logic [AW:0]      level,
  output logic             underflow,
  output logic             overflow,
  output logic             miss
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [AW:0]   CH_LVL = (AW+1)'(CH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] MID = DW'(1) << (DW-1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    idx_reg;
  logic             under_frame_reg;
  logic [CH*DW-1:0] stage_reg;
  logic [CH*DW-1:0] dac_reg;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [DW-1:0]    rd_data;

  logic [19:0]      cnt_reg;
  logic             tick_reg;
  logic             underflow_reg, overflow_reg, miss_reg;

  logic push, pop, frame_ok, under_evt, miss_evt;

  assign push    = wr & ~full;
  assign rd_data = mem[rd_ptr_reg];

  assign level    = level_reg;
  assign empty    = (level_reg == '0);
  assign full     = (level_reg == FULL_LVL);
  assign low      = (level_reg < fifo_threshold);
  assign dac_data = dac_reg;
  assign EN       = en;
  assign RST      = ~rst_n;
  assign underflow = underflow_reg;
  assign overflow  = overflow_reg;
  assign miss      = miss_reg;

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (en & clk_en) begin
      if (cnt_reg == clkdiv) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg + 20'd1;
        tick_reg <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick_reg) state_next = (level_reg >= CH_LVL) ? FETCH : LOAD;
      FETCH:   if (idx_reg == CW'(CH-1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state_reg == FETCH);
    frame_ok  = (state_reg == IDLE) && tick_reg && (level_reg >= CH_LVL);
    under_evt = (state_reg == IDLE) && tick_reg && (level_reg < CH_LVL);
    miss_evt  = tick_reg && (state_reg != IDLE);
  end

  // An underflow frame skips FETCH and goes straight to LOAD with the policy flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      under_frame_reg <= 1'b0;
      stage_reg       <= '0;
      dac_reg         <= '0;
    end else begin
      idx_reg <= (state_reg == FETCH) ? idx_reg + 1'b1 : '0;
      if (state_reg == IDLE) under_frame_reg <= under_evt;
      if (pop) stage_reg[32'(idx_reg)*DW +: DW] <= rd_data;
      if (state_reg == LOAD) begin
        if (!under_frame_reg) dac_reg <= stage_reg;
        else if (mode)        dac_reg <= {CH{MID}};
      end
    end
  end

  // A set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      miss_reg      <= 1'b0;
    end else begin
      underflow_reg <= under_evt | (underflow_reg & ~clr_flags);
      overflow_reg  <= (wr & full) | (overflow_reg & ~clr_flags);
      miss_reg      <= miss_evt | (miss_reg & ~clr_flags);
    end
  end

  logic unused_ok;
  assign unused_ok = frame_ok;

endmodule

// File: doc/dac_stream_mux.md
DAC_STREAM_MUX -- requirements
Module: dac_stream_mux

Interface
REQ-001 SHALL have parameter DW, default 10, meaning DAC sample width in bits (1..16).
REQ-002 SHALL have parameter CH, default 2, meaning number of DAC channels (1..4).
REQ-003 SHALL have parameter AW, default 5, meaning FIFO address width; depth = 2**AW words.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: en  input  1  block enable; clk_en  input  1  sample-timer enable; clkdiv  input  20  sample period minus one, in clk cycles.
REQ-006 SHALL have ports: wr  input  1  FIFO write strobe; data  input  DW  sample word; fifo_threshold  input  AW+1  low-level threshold.
REQ-007 SHALL have ports: mode  input  1  underflow policy (0 = hold last frame, 1 = drive midscale); clr_flags  input  1  clears sticky flags.
REQ-008 SHALL have ports: dac_data  output  CH*DW  channel outputs, channel k at bits [k*DW +: DW]; EN  output  1  copy of en; RST  output  1  ~rst_n.
REQ-009 SHALL have ports: empty, full, low  output  1 each  FIFO status; level  output  AW+1  FIFO occupancy; underflow, overflow, miss  output  1 each  sticky flags.

Function
REQ-010 SHALL implement a FIFO of 2**AW DW-bit words; level ranges 0..2**AW, with no aliasing at full.
REQ-011 SHALL write data when wr & ~full; wr while full SHALL drop the word and set overflow.
REQ-012 SHALL allow a simultaneous pop and push in one cycle, with level unchanged.
REQ-013 SHALL drive empty = (level == 0), full = (level == 2**AW), and low = (level < fifo_threshold), all combinational from level.
REQ-014 SHALL run a 20-bit sample counter while en & clk_en, counting 0..clkdiv; when it equals clkdiv it SHALL wrap to 0 and pulse tick high for one cycle.
REQ-015 The counter SHALL hold its value while en & clk_en is low; deasserting en mid-frame SHALL NOT abort a fetch already in progress.
REQ-016 SHALL implement FSM IDLE -> FETCH -> LOAD -> IDLE.
REQ-017 On tick in IDLE with level >= CH, the FSM SHALL enter FETCH and pop exactly CH words on CH consecutive cycles into staging registers for channel 0..CH-1, in that order.
REQ-018 LOAD SHALL last one cycle and copy all staging registers to dac_data simultaneously, so that no channel updates separately; dac_data updates CH+1 cycles after tick.
REQ-019 On tick in IDLE with level < CH, the block SHALL pop nothing, set underflow, and in the LOAD-equivalent cycle (tick+1) apply the mode policy.
REQ-020 Mode 0 SHALL leave dac_data unchanged; mode 1 SHALL set every channel to 2**(DW-1).
REQ-021 A tick arriving while in FETCH or LOAD SHALL be dropped and SHALL set miss; the minimum clkdiv for lossless operation is CH+1.
REQ-022 Partial frames SHALL remain in the FIFO for the next tick and SHALL NOT be discarded.
REQ-023 clr_flags SHALL clear underflow, overflow and miss the next cycle; a same-cycle set event SHALL take priority over the clear.
REQ-024 EN = en and RST = ~rst_n SHALL be combinational.

Reset
REQ-025 On rst_n low, asynchronously: FIFO pointers and level = 0, empty = 1, full = 0, counter = 0, tick = 0, FSM = IDLE, staging registers and dac_data = 0, and all sticky flags = 0.
REQ-026 FIFO memory contents SHALL NOT be reset; reset mid-FETCH SHALL abandon the frame, and the popped words are lost.

Verification
REQ-027 Scenario: CH=2, DW=10, clkdiv=9; write 0x001, 0x002, 0x003, 0x004; en=clk_en=1 -> dac_data={0x002,0x001} CH+1 cycles after the first tick, then {0x004,0x003} 10 cycles later, with level 4->2->0.
REQ-028 Scenario: write one word only, mode=1 -> tick sets underflow, dac_data = {0x200,0x200}, level stays 1; clr_flags -> underflow=0.
REQ-029 Scenario: AW=5; write 33 words -> full=1 and level=32 after 32 writes, and the 33rd write sets overflow with level still 32.
REQ-030 Scenario: clkdiv=1, CH=2, FIFO full -> every second tick sets miss, and frames are still delivered in order with no channel skew.
REQ-031 Scenario: fifo_threshold=8; fill to 7 -> low=1; write one more -> low=0; pop 2 with a simultaneous write -> level=7 and low=1.
REQ-032 Scenario: assert rst_n low during FETCH -> all outputs at reset values immediately, and no LOAD follows after release.
